// File: rtl/load_value_predictor.sv
// Last-value load predictor: tagged direct-mapped value table, EX/MEM tracking slots,
// verify-and-train in MEM, and a flush plus cooldown sequencer after a misprediction.
module load_value_predictor #(
  parameter int DATA_WIDTH      = 32,
  parameter int ADDR_WIDTH      = 32,
  parameter int INDEX_BITS      = 4,
  parameter int CONF_THRESHOLD  = 2,
  parameter int COOLDOWN_CYCLES = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  i_Stall,
  input  logic                  i_DEC_Valid,
  input  logic                  i_DEC_Is_Load,
  input  logic [ADDR_WIDTH-1:0] i_DEC_PC,
  input  logic [DATA_WIDTH-1:0] i_MEM_Load_Data,
  output logic                  o_Predict_Made,
  output logic [DATA_WIDTH-1:0] o_Predicted_Data,
  output logic                  o_Flush,
  output logic [ADDR_WIDTH-1:0] o_Replay_PC,
  output logic [15:0]           o_Predict_Count,
  output logic [15:0]           o_Mispredict_Count
);

  localparam int ENTRIES = 1 << INDEX_BITS;
  localparam int TAG_W   = ADDR_WIDTH - INDEX_BITS - 2;
  localparam int CNT_W   = (COOLDOWN_CYCLES > 1) ? $clog2(COOLDOWN_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(COOLDOWN_CYCLES - 1);
  // A threshold above 3 can never be reached by a 2-bit confidence: clamp to 4.
  localparam logic [2:0] CONF_THR = (CONF_THRESHOLD > 3) ? 3'd4 : 3'(CONF_THRESHOLD);

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_COOL = 1'b1
  } state_e;

  typedef struct packed {
    logic                  valid_load;
    logic                  pred;
    logic [DATA_WIDTH-1:0] pred_data;
    logic [ADDR_WIDTH-1:0] pc;
    logic [INDEX_BITS-1:0] index;
  } slot_t;

  function automatic logic [1:0] conf_inc(input logic [1:0] c);
    if (c == 2'd3) begin
      conf_inc = 2'd3;
    end else begin
      conf_inc = c + 2'd1;
    end
  endfunction

  function automatic logic [15:0] cnt_inc(input logic [15:0] c);
    if (c == 16'hFFFF) begin
      cnt_inc = 16'hFFFF;
    end else begin
      cnt_inc = c + 16'd1;
    end
  endfunction

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cool_q, cool_d;
  slot_t            ex_q, ex_d, mem_q, mem_d, dec_slot_s;
  logic [15:0]      pcnt_q, pcnt_d, mcnt_q, mcnt_d;

  logic [ENTRIES-1:0]    tbl_valid_q;
  logic [TAG_W-1:0]      tbl_tag_q   [ENTRIES];
  logic [DATA_WIDTH-1:0] tbl_value_q [ENTRIES];
  logic [1:0]            tbl_conf_q  [ENTRIES];

  logic [INDEX_BITS-1:0] dec_idx_s;
  logic [TAG_W-1:0]      dec_tag_s, mem_tag_s;
  logic                  dec_load_s, dec_hit_s;
  logic                  verify_s, entry_hit_s, pred_eq_s, value_eq_s, flush_s;
  logic                  wr_en_s;
  logic [1:0]            wr_conf_s;

  assign dec_idx_s  = i_DEC_PC[INDEX_BITS+1:2];
  assign dec_tag_s  = i_DEC_PC[ADDR_WIDTH-1:INDEX_BITS+2];
  assign dec_load_s = i_DEC_Valid & i_DEC_Is_Load;
  assign dec_hit_s  = dec_load_s & tbl_valid_q[dec_idx_s]
                    & (tbl_tag_q[dec_idx_s] == dec_tag_s)
                    & ({1'b0, tbl_conf_q[dec_idx_s]} >= CONF_THR)
                    & (state_q == ST_RUN);

  // Build the slot entering EX from the DECODE lookup.
  always_comb begin
    dec_slot_s            = '0;
    dec_slot_s.valid_load = dec_load_s;
    dec_slot_s.pred       = dec_hit_s;
    dec_slot_s.pred_data  = dec_hit_s ? tbl_value_q[dec_idx_s] : '0;
    dec_slot_s.pc         = i_DEC_PC;
    dec_slot_s.index      = dec_idx_s;
  end

  // Reset wins over a pending verify, so nothing trains or flushes in that cycle.
  assign verify_s    = mem_q.valid_load & ~i_Stall & ~reset;
  assign mem_tag_s   = mem_q.pc[ADDR_WIDTH-1:INDEX_BITS+2];
  assign entry_hit_s = tbl_valid_q[mem_q.index] & (tbl_tag_q[mem_q.index] == mem_tag_s);
  assign pred_eq_s   = (i_MEM_Load_Data == mem_q.pred_data);
  assign value_eq_s  = (i_MEM_Load_Data == tbl_value_q[mem_q.index]);
  assign flush_s     = verify_s & mem_q.pred & ~pred_eq_s;

  // Training decision: every verified load rewrites its entry; only confidence varies.
  always_comb begin
    wr_en_s   = 1'b0;
    wr_conf_s = 2'd0;
    if (verify_s) begin
      wr_en_s = 1'b1;
      if (mem_q.pred) begin
        if (pred_eq_s && entry_hit_s) begin
          wr_conf_s = conf_inc(tbl_conf_q[mem_q.index]);
        end else begin
          wr_conf_s = 2'd0;
        end
      end else begin
        if (entry_hit_s && value_eq_s) begin
          wr_conf_s = conf_inc(tbl_conf_q[mem_q.index]);
        end else begin
          wr_conf_s = 2'd0;
        end
      end
    end else begin
      wr_en_s   = 1'b0;
      wr_conf_s = 2'd0;
    end
  end

  // Verified-prediction and misprediction statistics.
  always_comb begin
    pcnt_d = pcnt_q;
    mcnt_d = mcnt_q;
    if (verify_s && mem_q.pred) begin
      pcnt_d = cnt_inc(pcnt_q);
      if (!pred_eq_s) begin
        mcnt_d = cnt_inc(mcnt_q);
      end else begin
        mcnt_d = mcnt_q;
      end
    end else begin
      pcnt_d = pcnt_q;
      mcnt_d = mcnt_q;
    end
  end

  // Pipeline slot advance; a flush squashes EX and the incoming DECODE load.
  always_comb begin
    ex_d  = ex_q;
    mem_d = mem_q;
    if (i_Stall) begin
      ex_d  = ex_q;
      mem_d = mem_q;
    end else if (flush_s) begin
      ex_d  = '0;
      mem_d = '0;
    end else begin
      ex_d  = dec_slot_s;
      mem_d = ex_q;
    end
  end

  // Cooldown sequencer next state.
  always_comb begin
    state_d = state_q;
    cool_d  = cool_q;
    if (flush_s) begin
      state_d = ST_COOL;
      cool_d  = CNT_LOAD;
    end else begin
      case (state_q)
        ST_RUN: begin
          state_d = ST_RUN;
          cool_d  = cool_q;
        end
        ST_COOL: begin
          if (i_Stall) begin
            state_d = ST_COOL;
            cool_d  = cool_q;
          end else if (cool_q == '0) begin
            state_d = ST_RUN;
            cool_d  = '0;
          end else begin
            state_d = ST_COOL;
            cool_d  = cool_q - CNT_W'(1'b1);
          end
        end
        default: begin
          state_d = ST_RUN;
          cool_d  = '0;
        end
      endcase
    end
  end

  // Control, slot and counter registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_RUN;
      cool_q  <= '0;
      ex_q    <= '0;
      mem_q   <= '0;
      pcnt_q  <= 16'd0;
      mcnt_q  <= 16'd0;
    end else begin
      state_q <= state_d;
      cool_q  <= cool_d;
      ex_q    <= ex_d;
      mem_q   <= mem_d;
      pcnt_q  <= pcnt_d;
      mcnt_q  <= mcnt_d;
    end
  end

  // Table valid and confidence bits.
  always_ff @(posedge clock) begin
    if (reset) begin
      tbl_valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tbl_conf_q[i] <= 2'd0;
      end
    end else if (wr_en_s) begin
      tbl_valid_q[mem_q.index] <= 1'b1;
      tbl_conf_q[mem_q.index]  <= wr_conf_s;
    end else begin
      tbl_valid_q <= tbl_valid_q;
    end
  end

  // Table tag and value payload; meaningless until the valid bit is set.
  always_ff @(posedge clock) begin
    if (wr_en_s) begin
      tbl_tag_q[mem_q.index]   <= mem_tag_s;
      tbl_value_q[mem_q.index] <= i_MEM_Load_Data;
    end
  end

  assign o_Predict_Made     = ex_q.valid_load & ex_q.pred;
  assign o_Predicted_Data   = ex_q.pred_data;
  assign o_Flush            = flush_s;
  assign o_Replay_PC        = flush_s ? (mem_q.pc + ADDR_WIDTH'(3'd4)) : '0;
  assign o_Predict_Count    = pcnt_q;
  assign o_Mispredict_Count = mcnt_q;

endmodule

// File: tb/tb_load_value_predictor.sv
// Directed bench for load_value_predictor: table of single-load vectors plus
// hand sequences for back-to-back squash, cooldown, saturation and mid-run reset.
module tb_load_value_predictor;

  logic        clock = 1'b0;
  logic        reset;
  logic        i_Stall;
  logic        i_DEC_Valid;
  logic        i_DEC_Is_Load;
  logic [31:0] i_DEC_PC;
  logic [31:0] i_MEM_Load_Data;
  logic        o_Predict_Made;
  logic [31:0] o_Predicted_Data;
  logic        o_Flush;
  logic [31:0] o_Replay_PC;
  logic [15:0] o_Predict_Count;
  logic [15:0] o_Mispredict_Count;

  load_value_predictor dut (
    .clock              (clock),
    .reset              (reset),
    .i_Stall            (i_Stall),
    .i_DEC_Valid        (i_DEC_Valid),
    .i_DEC_Is_Load      (i_DEC_Is_Load),
    .i_DEC_PC           (i_DEC_PC),
    .i_MEM_Load_Data    (i_MEM_Load_Data),
    .o_Predict_Made     (o_Predict_Made),
    .o_Predicted_Data   (o_Predicted_Data),
    .o_Flush            (o_Flush),
    .o_Replay_PC        (o_Replay_PC),
    .o_Predict_Count    (o_Predict_Count),
    .o_Mispredict_Count (o_Mispredict_Count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
    int          stl;
    logic        exp_pred;
    logic [31:0] exp_pdata;
    logic        exp_flush;
    logic [31:0] exp_replay;
    logic [15:0] exp_pcnt;
    logic [15:0] exp_mcnt;
  } vec_t;

  vec_t vecs [19];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_dec(input logic v, input logic [31:0] pc);
    i_DEC_Valid   = v;
    i_DEC_Is_Load = v;
    i_DEC_PC      = pc;
  endtask

  // One load through DECODE, EX (optionally stalled), MEM (optionally stalled), retire.
  task automatic run_vec(input vec_t v, input int n);
    drive_dec(1'b1, v.pc);
    i_MEM_Load_Data = 32'h0;
    @(negedge clock);
    drive_dec(1'b0, 32'h0);
    chk($sformatf("v%0d_pred", n), {31'd0, o_Predict_Made}, {31'd0, v.exp_pred});
    if (v.exp_pred) chk($sformatf("v%0d_pdata", n), o_Predicted_Data, v.exp_pdata);
    for (int s = 0; s < v.stl; s++) begin
      i_Stall = 1'b1;
      @(negedge clock);
      chk($sformatf("v%0d_exhold_pred", n), {31'd0, o_Predict_Made}, {31'd0, v.exp_pred});
      if (v.exp_pred) chk($sformatf("v%0d_exhold_pdata", n), o_Predicted_Data, v.exp_pdata);
    end
    i_Stall = 1'b0;
    @(negedge clock);
    for (int s = 0; s < v.stl; s++) begin
      i_Stall         = 1'b1;
      i_MEM_Load_Data = v.data ^ 32'hFFFF_FFFF;
      #1;
      chk($sformatf("v%0d_stall_flush", n), {31'd0, o_Flush}, 32'd0);
      @(negedge clock);
    end
    i_Stall         = 1'b0;
    i_MEM_Load_Data = v.data;
    #1;
    chk($sformatf("v%0d_flush", n), {31'd0, o_Flush}, {31'd0, v.exp_flush});
    if (v.exp_flush) chk($sformatf("v%0d_replay", n), o_Replay_PC, v.exp_replay);
    @(negedge clock);
    i_MEM_Load_Data = 32'h0;
    chk($sformatf("v%0d_pcnt", n), {16'd0, o_Predict_Count}, {16'd0, v.exp_pcnt});
    chk($sformatf("v%0d_mcnt", n), {16'd0, o_Mispredict_Count}, {16'd0, v.exp_mcnt});
  endtask

  initial begin
    logic saw_flush;
    // pc, data, stall, pred, pdata, flush, replay, pcnt, mcnt
    vecs[0]  = '{32'h40,  32'h1234, 0, 1'b0, 32'h0,    1'b0, 32'h0,  16'd0, 16'd0};
    vecs[1]  = '{32'h40,  32'h1234, 0, 1'b0, 32'h0,    1'b0, 32'h0,  16'd0, 16'd0};
    vecs[2]  = '{32'h40,  32'h1234, 0, 1'b0, 32'h0,    1'b0, 32'h0,  16'd0, 16'd0};
    vecs[3]  = '{32'h40,  32'h1234, 0, 1'b1, 32'h1234, 1'b0, 32'h0,  16'd1, 16'd0};
    vecs[4]  = '{32'h40,  32'h5678, 0, 1'b1, 32'h1234, 1'b1, 32'h44, 16'd2, 16'd1};
    vecs[5]  = '{32'h40,  32'h5678, 0, 1'b0, 32'h0,    1'b0, 32'h0,  16'd2, 16'd1};
    vecs[6]  = '{32'h40,  32'h5678, 0, 1'b0, 32'h0,    1'b0, 32'h0,  16'd2, 16'd1};
    vecs[7]  = '{32'h40,  32'h5678, 3, 1'b1, 32'h5678, 1'b0, 32'h0,  16'd3, 16'd1};
    vecs[8]  = '{32'h440, 32'hAAAA, 0, 1'b0, 32'h0,    1'b0, 32'h0,  16'd3, 16'd1};
    vecs[9]  = '{32'h40,  32'h5678, 0, 1'b0, 32'h0,    1'b0, 32'h0,  16'd3, 16'd1};
    vecs[10] = '{32'h84,  32'h9999, 0, 1'b0, 32'h0,    1'b0, 32'h0,  16'd3, 16'd1};
    vecs[11] = '{32'h84,  32'h9999, 0, 1'b0, 32'h0,    1'b0, 32'h0,  16'd3, 16'd1};
    vecs[12] = '{32'h84,  32'h9999, 0, 1'b0, 32'h0,    1'b0, 32'h0,  16'd3, 16'd1};
    vecs[13] = '{32'h84,  32'h9999, 0, 1'b1, 32'h9999, 1'b0, 32'h0,  16'd4, 16'd1};
    vecs[14] = '{32'h84,  32'h1111, 2, 1'b1, 32'h9999, 1'b1, 32'h88, 16'd5, 16'd2};
    vecs[15] = '{32'h40,  32'h5678, 0, 1'b0, 32'h0,    1'b0, 32'h0,  16'd5, 16'd2};
    vecs[16] = '{32'h40,  32'h5678, 0, 1'b0, 32'h0,    1'b0, 32'h0,  16'd5, 16'd2};
    vecs[17] = '{32'h84,  32'h1111, 0, 1'b0, 32'h0,    1'b0, 32'h0,  16'd5, 16'd2};
    vecs[18] = '{32'h84,  32'h1111, 0, 1'b0, 32'h0,    1'b0, 32'h0,  16'd5, 16'd2};

    reset           = 1'b1;
    i_Stall         = 1'b0;
    i_MEM_Load_Data = 32'h0;
    drive_dec(1'b0, 32'h0);
    repeat (2) @(negedge clock);
    chk("rst_pred",   {31'd0, o_Predict_Made}, 32'd0);
    chk("rst_pdata",  o_Predicted_Data, 32'd0);
    chk("rst_flush",  {31'd0, o_Flush}, 32'd0);
    chk("rst_replay", o_Replay_PC, 32'd0);
    chk("rst_pcnt",   {16'd0, o_Predict_Count}, 32'd0);
    chk("rst_mcnt",   {16'd0, o_Mispredict_Count}, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 19; i++) run_vec(vecs[i], i);

    // Mispredict on 0x84 with a predicted 0x40 right behind it, then cooldown.
    i_MEM_Load_Data = 32'h5678;
    drive_dec(1'b1, 32'h84);
    @(negedge clock);
    chk("seq_c1_pred",  {31'd0, o_Predict_Made}, 32'd1);
    chk("seq_c1_pdata", o_Predicted_Data, 32'h1111);
    drive_dec(1'b1, 32'h40);
    @(negedge clock);
    chk("seq_c2_pred",  {31'd0, o_Predict_Made}, 32'd1);
    chk("seq_c2_pdata", o_Predicted_Data, 32'h5678);
    i_MEM_Load_Data = 32'h2222;
    #1;
    chk("seq_c2_flush",  {31'd0, o_Flush}, 32'd1);
    chk("seq_c2_replay", o_Replay_PC, 32'h88);
    @(negedge clock);
    i_MEM_Load_Data = 32'h5678;
    #1;
    chk("seq_c3_squash", {31'd0, o_Predict_Made}, 32'd0);
    chk("seq_c3_flush",  {31'd0, o_Flush}, 32'd0);
    for (int c = 4; c <= 7; c++) begin
      @(negedge clock);
      chk($sformatf("seq_c%0d_cool", c), {31'd0, o_Predict_Made}, 32'd0);
    end
    @(negedge clock);
    drive_dec(1'b0, 32'h0);
    chk("seq_c8_pred",  {31'd0, o_Predict_Made}, 32'd1);
    chk("seq_c8_pdata", o_Predicted_Data, 32'h5678);
    repeat (2) @(negedge clock);
    chk("seq_pcnt", {16'd0, o_Predict_Count}, 32'd7);
    chk("seq_mcnt", {16'd0, o_Mispredict_Count}, 32'd3);

    // Long run of correct predictions drives the predict counter into saturation.
    saw_flush = 1'b0;
    drive_dec(1'b1, 32'h40);
    for (int k = 0; k < 65540; k++) begin
      @(negedge clock);
      if (o_Flush) saw_flush = 1'b1;
    end
    drive_dec(1'b0, 32'h0);
    repeat (3) @(negedge clock);
    chk("sat_pcnt",  {16'd0, o_Predict_Count}, 32'h0000_FFFF);
    chk("sat_mcnt",  {16'd0, o_Mispredict_Count}, 32'd3);
    chk("sat_flush", {31'd0, saw_flush}, 32'd0);

    // Reset arrives while a mispredicting load sits in MEM.
    drive_dec(1'b1, 32'h40);
    @(negedge clock);
    drive_dec(1'b0, 32'h0);
    chk("mrst_pred", {31'd0, o_Predict_Made}, 32'd1);
    @(negedge clock);
    i_MEM_Load_Data = 32'h1;
    reset           = 1'b1;
    #1;
    chk("mrst_flush", {31'd0, o_Flush}, 32'd0);
    @(negedge clock);
    reset           = 1'b0;
    i_MEM_Load_Data = 32'h0;
    chk("mrst_pcnt", {16'd0, o_Predict_Count}, 32'd0);
    chk("mrst_mcnt", {16'd0, o_Mispredict_Count}, 32'd0);
    drive_dec(1'b1, 32'h40);
    @(negedge clock);
    drive_dec(1'b0, 32'h0);
    chk("mrst_table", {31'd0, o_Predict_Made}, 32'd0);
    repeat (2) @(negedge clock);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
